// File: rtl/mem_pkg.sv
// Shared types, widths and helpers for the large_memory_v2 data memory.
package mem_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned CNT_WIDTH  = 3;

  typedef enum logic {
    W_IDLE,
    W_DONE
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_READY
  } r_state_t;

  // Word index (byte address / 4) must fall below the configured depth.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr, input int unsigned depth);
    return ADDR_WIDTH'(addr[ADDR_WIDTH-1:2]) < depth;
  endfunction

endpackage

// File: rtl/bram_sp_pipe.sv
// Inferred single-port RAM, byte write enables, read-first, with a
// READ_LATENCY-deep output pipeline.
module bram_sp_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned INDEX_WIDTH  = 20,
  parameter int unsigned DEPTH        = 655360,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                   clk,
  input  logic [INDEX_WIDTH-1:0] idx_i,
  input  logic                   we_i,
  input  logic [STRB_WIDTH-1:0]  strb_i,
  input  logic [DATA_WIDTH-1:0]  wdata_i,
  output logic [DATA_WIDTH-1:0]  rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY];

  // Stage 0 samples the old word even on a write cycle (read-first).
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (strb_i[b]) begin
          mem_q[idx_i][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
    pipe_q[0] <= mem_q[idx_i];
    for (int s = 1; s < READ_LATENCY; s++) begin
      pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign rdata_o = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/large_memory_v2.sv
// Handshaked data memory: write/read FSMs sharing one single-port RAM,
// write priority, range checking and a sticky first-fault record.
module large_memory_v2
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned INDEX_WIDTH  = 20,
  parameter int unsigned DEPTH        = 655360,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [STRB_WIDTH-1:0] in_strb,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] out_addr,
  input  logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_ready,
  input  logic                  error_clear,
  output logic                  addr_error,
  output logic [ADDR_WIDTH-1:0] error_addr,
  output logic                  error_is_write
);

  w_state_t               w_state_q, w_state_d;
  r_state_t               r_state_q, r_state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   rd_oor_q, rd_oor_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_ready_q, out_ready_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   addr_error_q, addr_error_d;
  logic [ADDR_WIDTH-1:0]  error_addr_q, error_addr_d;
  logic                   error_is_write_q, error_is_write_d;

  logic                   wr_in_range_c, rd_in_range_c;
  logic                   wr_accept_c, rd_accept_c;
  logic                   wr_fault_c, rd_fault_c;
  logic                   ram_we_c;
  logic [INDEX_WIDTH-1:0] ram_idx_c;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  assign wr_in_range_c = in_range(in_addr, DEPTH);
  assign rd_in_range_c = in_range(out_addr, DEPTH);
  assign wr_accept_c   = (w_state_q == W_IDLE) && in_valid;
  assign rd_accept_c   = (r_state_q == R_IDLE) && out_valid && !in_valid;
  assign wr_fault_c    = wr_accept_c && !wr_in_range_c;
  assign rd_fault_c    = rd_accept_c && !rd_in_range_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q        <= W_IDLE;
      r_state_q        <= R_IDLE;
      cnt_q            <= '0;
      rd_oor_q         <= 1'b0;
      in_ready_q       <= 1'b0;
      out_ready_q      <= 1'b0;
      out_data_q       <= '0;
      addr_error_q     <= 1'b0;
      error_addr_q     <= '0;
      error_is_write_q <= 1'b0;
    end else begin
      w_state_q        <= w_state_d;
      r_state_q        <= r_state_d;
      cnt_q            <= cnt_d;
      rd_oor_q         <= rd_oor_d;
      in_ready_q       <= in_ready_d;
      out_ready_q      <= out_ready_d;
      out_data_q       <= out_data_d;
      addr_error_q     <= addr_error_d;
      error_addr_q     <= error_addr_d;
      error_is_write_q <= error_is_write_d;
    end
  end

  // Next state: a pending write preempts any read still waiting on the RAM.
  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    cnt_d     = cnt_q;
    rd_oor_d  = rd_oor_q;
    case (w_state_q)
      W_IDLE:  if (in_valid) w_state_d = W_DONE;
      W_DONE:  w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    case (r_state_q)
      R_IDLE: begin
        if (rd_accept_c) begin
          r_state_d = R_WAIT;
          cnt_d     = CNT_WIDTH'(READ_LATENCY);
          rd_oor_d  = !rd_in_range_c;
        end
      end
      R_WAIT: begin
        if (!out_valid || in_valid) r_state_d = R_IDLE;
        else if (cnt_q == CNT_WIDTH'(1)) r_state_d = R_READY;
        else cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      R_READY: r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Outputs, RAM port control and the error record.
  always_comb begin
    in_ready_d       = (w_state_d == W_DONE);
    out_ready_d      = (r_state_d == R_READY);
    out_data_d       = out_data_q;
    ram_we_c         = wr_accept_c && wr_in_range_c;
    ram_idx_c        = '0;
    addr_error_d     = addr_error_q;
    error_addr_d     = error_addr_q;
    error_is_write_d = error_is_write_q;
    if ((r_state_q == R_WAIT) && (r_state_d == R_READY)) begin
      out_data_d = rd_oor_q ? '0 : ram_rdata;
    end
    if (in_valid) begin
      if (wr_in_range_c) ram_idx_c = in_addr[INDEX_WIDTH+1:2];
    end else if (rd_in_range_c) begin
      ram_idx_c = out_addr[INDEX_WIDTH+1:2];
    end
    if ((wr_fault_c || rd_fault_c) && (!addr_error_q || error_clear)) begin
      addr_error_d     = 1'b1;
      error_addr_d     = wr_fault_c ? in_addr : out_addr;
      error_is_write_d = wr_fault_c;
    end else if (error_clear) begin
      addr_error_d     = 1'b0;
      error_addr_d     = '0;
      error_is_write_d = 1'b0;
    end
  end

  bram_sp_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .DEPTH       (DEPTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_ram (
    .clk    (clk),
    .idx_i  (ram_idx_c),
    .we_i   (ram_we_c),
    .strb_i (in_strb),
    .wdata_i(in_data),
    .rdata_o(ram_rdata)
  );

  assign in_ready       = in_ready_q;
  assign out_ready      = out_ready_q;
  assign out_data       = out_data_q;
  assign addr_error     = addr_error_q;
  assign error_addr     = error_addr_q;
  assign error_is_write = error_is_write_q;

endmodule

// File: tb/tb_large_memory_v2.sv
// Bench for large_memory_v2: two instances (read latency 1 and 3) checked
// against an associative-array memory model and a first-fault record model.
module tb_large_memory_v2;

  localparam int unsigned DEPTH = 655360;
  localparam int unsigned NDUT  = 2;

  logic        clk;
  logic        reset_n        [NDUT];
  logic [31:0] in_addr        [NDUT];
  logic [31:0] in_data        [NDUT];
  logic [3:0]  in_strb        [NDUT];
  logic        in_valid       [NDUT];
  logic        in_ready       [NDUT];
  logic [31:0] out_addr       [NDUT];
  logic        out_valid      [NDUT];
  logic [31:0] out_data       [NDUT];
  logic        out_ready      [NDUT];
  logic        error_clear    [NDUT];
  logic        addr_error     [NDUT];
  logic [31:0] error_addr     [NDUT];
  logic        error_is_write [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [bit [31:0]];
  bit          m_err   [NDUT];
  logic [31:0] m_eaddr [NDUT];
  bit          m_ewr   [NDUT];
  logic [31:0] m_last  [NDUT];
  logic [31:0] pool    [NDUT][8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    large_memory_v2 #(.READ_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk           (clk),
      .reset_n       (reset_n[g]),
      .in_addr       (in_addr[g]),
      .in_data       (in_data[g]),
      .in_strb       (in_strb[g]),
      .in_valid      (in_valid[g]),
      .in_ready      (in_ready[g]),
      .out_addr      (out_addr[g]),
      .out_valid     (out_valid[g]),
      .out_data      (out_data[g]),
      .out_ready     (out_ready[g]),
      .error_clear   (error_clear[g]),
      .addr_error    (addr_error[g]),
      .error_addr    (error_addr[g]),
      .error_is_write(error_is_write[g])
    );
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit oor(input logic [31:0] a);
    return (a >> 2) >= DEPTH;
  endfunction

  function automatic bit [31:0] key(input int d, input logic [31:0] a);
    return {d[0], 1'b0, a[31:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err(input int d);
    chk("err_flag", 32'(addr_error[d]), 32'(m_err[d]));
    chk("err_addr", error_addr[d], m_eaddr[d]);
    chk("err_is_write", 32'(error_is_write[d]), 32'(m_ewr[d]));
  endtask

  task automatic mdl_err(input int d, input logic [31:0] a, input bit is_w, input bit clr);
    if (oor(a) && (!m_err[d] || clr)) begin
      m_err[d] = 1'b1; m_eaddr[d] = a; m_ewr[d] = is_w;
    end else if (clr) begin
      m_err[d] = 1'b0; m_eaddr[d] = 32'h0; m_ewr[d] = 1'b0;
    end
  endtask

  task automatic mdl_write(input int d, input logic [31:0] a, input logic [31:0] data,
                           input logic [3:0] strb);
    logic [31:0] w;
    if (oor(a)) return;
    w = mdl.exists(key(d, a)) ? mdl[key(d, a)] : 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    mdl[key(d, a)] = w;
  endtask

  task automatic wait_ready(input int d, output int n);
    n = 1;
    while (out_ready[d] !== 1'b1 && n <= 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] data,
                          input logic [3:0] strb, input bit clr);
    chk("wr_pre_ready", 32'(in_ready[d]), 32'h0);
    in_addr[d] = a; in_data[d] = data; in_strb[d] = strb;
    in_valid[d] = 1'b1; error_clear[d] = clr;
    tick();
    in_valid[d] = 1'b0; error_clear[d] = 1'b0;
    chk("wr_ready", 32'(in_ready[d]), 32'h1);
    mdl_write(d, a, data, strb);
    mdl_err(d, a, 1'b1, clr);
    chk_err(d);
    tick();
    chk("wr_ready_clr", 32'(in_ready[d]), 32'h0);
  endtask

  task automatic do_read(input int d, input logic [31:0] a, input bit clr, output logic [31:0] got);
    int n;
    logic [31:0] exp;
    out_addr[d] = a; out_valid[d] = 1'b1; error_clear[d] = clr;
    tick();
    error_clear[d] = 1'b0;
    mdl_err(d, a, 1'b0, clr);
    chk_err(d);
    chk("rd_wait_hold", out_data[d], m_last[d]);
    wait_ready(d, n);
    out_valid[d] = 1'b0;
    exp = (oor(a) || !mdl.exists(key(d, a))) ? 32'h0 : mdl[key(d, a)];
    chk("rd_latency", 32'(n), 32'(lat(d) + 1));
    chk("rd_data", out_data[d], exp);
    got = out_data[d];
    m_last[d] = exp;
    tick();
    chk("rd_ready_clr", 32'(out_ready[d]), 32'h0);
    chk("rd_hold", out_data[d], exp);
  endtask

  initial begin
    logic [31:0] got, a;
    int n, d;

    for (int i = 0; i < NDUT; i++) begin
      reset_n[i] = 1'b0; in_addr[i] = '0; in_data[i] = '0; in_strb[i] = '0;
      in_valid[i] = 1'b0; out_addr[i] = '0; out_valid[i] = 1'b0; error_clear[i] = 1'b0;
      m_err[i] = 1'b0; m_eaddr[i] = '0; m_ewr[i] = 1'b0; m_last[i] = '0;
    end
    tick(); tick();
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_in_ready", 32'(in_ready[i]), 32'h0);
      chk("rst_out_ready", 32'(out_ready[i]), 32'h0);
      chk("rst_out_data", out_data[i], 32'h0);
      chk_err(i);
      reset_n[i] = 1'b1;
    end
    tick();

    // Basic write then read on both latencies
    for (int i = 0; i < NDUT; i++) begin
      do_write(i, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
      do_read(i, 32'h100, 1'b0, got);
      chk("basic_data", got, 32'hDEADBEEF);
    end

    // Byte-strobe merge
    do_write(0, 32'h200, 32'h11223344, 4'hF, 1'b0);
    do_write(0, 32'h200, 32'hAABBCCDD, 4'h5, 1'b0);
    do_read(0, 32'h200, 1'b0, got);
    chk("strb_merge", got, 32'h11BB33DD);

    // Simultaneous write and read: write first, read follows
    in_addr[0] = 32'h300; in_data[0] = 32'h0BADF00D; in_strb[0] = 4'hF; in_valid[0] = 1'b1;
    out_addr[0] = 32'h300; out_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    chk("simul_wr_ready", 32'(in_ready[0]), 32'h1);
    mdl_write(0, 32'h300, 32'h0BADF00D, 4'hF);
    wait_ready(0, n);
    out_valid[0] = 1'b0;
    chk("simul_rd_latency", 32'(n), 32'(lat(0) + 2));
    chk("simul_rd_data", out_data[0], 32'h0BADF00D);
    m_last[0] = 32'h0BADF00D;
    tick();

    // Write during R_WAIT aborts and reissues the read (latency 3)
    out_addr[1] = 32'h100; out_valid[1] = 1'b1;
    tick();
    chk("abort_w1_ready", 32'(out_ready[1]), 32'h0);
    tick();
    in_addr[1] = 32'h100; in_data[1] = 32'h600DCAFE; in_strb[1] = 4'hF; in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    chk("abort_wr_ready", 32'(in_ready[1]), 32'h1);
    chk("abort_no_rd_ready", 32'(out_ready[1]), 32'h0);
    chk("abort_data_held", out_data[1], m_last[1]);
    mdl_write(1, 32'h100, 32'h600DCAFE, 4'hF);
    tick();
    wait_ready(1, n);
    out_valid[1] = 1'b0;
    chk("reissue_latency", 32'(n), 32'(lat(1) + 1));
    chk("reissue_data", out_data[1], 32'h600DCAFE);
    m_last[1] = 32'h600DCAFE;
    tick();

    // out_valid dropped during R_WAIT: silent abort
    out_addr[1] = 32'h100; out_valid[1] = 1'b1;
    tick();
    out_valid[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drop_no_ready", 32'(out_ready[1]), 32'h0);
    end
    chk("drop_data_held", out_data[1], m_last[1]);

    // Out-of-range accesses and the error record
    do_write(0, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0);
    do_write(0, 32'h00280000, 32'h12345678, 4'hF, 1'b0);
    chk("oor_wr_flag", 32'(addr_error[0]), 32'h1);
    chk("oor_wr_addr", error_addr[0], 32'h00280000);
    chk("oor_wr_is_write", 32'(error_is_write[0]), 32'h1);
    do_write(0, 32'h00400100, 32'h55555555, 4'hF, 1'b0);
    do_read(0, 32'h100, 1'b0, got);
    chk("oor_no_alias_100", got, 32'hDEADBEEF);
    do_read(0, 32'h0, 1'b0, got);
    chk("oor_no_alias_0", got, 32'hCAFEF00D);
    do_read(0, 32'h00300000, 1'b0, got);
    chk("oor_rd_zero", got, 32'h0);
    chk("oor_rd_keeps_addr", error_addr[0], 32'h00280000);
    do_read(0, 32'h00300000, 1'b1, got);
    chk("clr_fault_flag", 32'(addr_error[0]), 32'h1);
    chk("clr_fault_addr", error_addr[0], 32'h00300000);
    chk("clr_fault_is_write", 32'(error_is_write[0]), 32'h0);
    do_write(0, 32'h300, 32'h01020304, 4'hF, 1'b1);
    chk("clr_only_flag", 32'(addr_error[0]), 32'h0);

    // Reset mid-R_WAIT drops the read and clears outputs
    do_write(1, 32'h00280000, 32'h0, 4'hF, 1'b0);
    out_addr[1] = 32'h100; out_valid[1] = 1'b1;
    tick(); tick();
    reset_n[1] = 1'b0;
    #1;
    chk("rst_mid_out_ready", 32'(out_ready[1]), 32'h0);
    chk("rst_mid_addr_error", 32'(addr_error[1]), 32'h0);
    chk("rst_mid_out_data", out_data[1], 32'h0);
    out_valid[1] = 1'b0;
    m_err[1] = 1'b0; m_eaddr[1] = '0; m_ewr[1] = 1'b0; m_last[1] = '0;
    tick(); tick();
    reset_n[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_no_pulse", 32'(out_ready[1]), 32'h0);
    end
    do_read(1, 32'h100, 1'b0, got);
    chk("rst_ram_kept", got, 32'h600DCAFE);

    // Randomized traffic against the model
    for (int i = 0; i < NDUT; i++) begin
      for (int j = 0; j < 8; j++) begin
        pool[i][j] = (32'($urandom_range(DEPTH - 1, 0)) << 2) | 32'($urandom_range(3, 0));
        do_write(i, pool[i][j], $urandom, 4'hF, 1'b0);
      end
    end
    for (int i = 0; i < 200; i++) begin
      d = int'($urandom_range(1, 0));
      if ($urandom_range(11, 0) == 0) a = 32'($urandom_range(32'h3FFF_FFFF, DEPTH)) << 2;
      else a = pool[d][$urandom_range(7, 0)];
      if ($urandom_range(1, 0) == 0)
        do_write(d, a, $urandom, 4'($urandom_range(15, 0)), $urandom_range(15, 0) == 0);
      else
        do_read(d, a, $urandom_range(15, 0) == 0, got);
      repeat ($urandom_range(2, 0)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/large_memory_v2.md
Name: large_memory_v2

Overview:
- Parametrised successor to the single-port block-RAM data memory used by the core's load/store unit.
- One write channel and one read channel, each with a valid/ready handshake, sharing one inferred single-port RAM.
- Adds configurable depth, data width and RAM read latency, plus per-byte write strobes.
- Out-of-range writes are suppressed and out-of-range reads return zero.
- Captures the first faulting address in a sticky, clearable error record.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- INDEX_WIDTH, 20, RAM word-index width.
- DEPTH, 655360, number of valid words; DEPTH <= 2**INDEX_WIDTH.
- READ_LATENCY, 1, RAM output pipeline stages; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_addr  in  32  write byte address; word index = in_addr[INDEX_WIDTH+1:2].
- in_data  in  DATA_WIDTH  write data.
- in_strb  in  DATA_WIDTH/8  byte write enables.
- in_valid  in  1  write request.
- in_ready  out  1  one-cycle write-done pulse.
- out_addr  in  32  read byte address.
- out_valid  in  1  read request.
- out_data  out  DATA_WIDTH  read data; registered and held until the next read completes.
- out_ready  out  1  one-cycle read-done pulse.
- error_clear  in  1  clears the error record.
- addr_error  out  1  sticky out-of-range flag.
- error_addr  out  32  byte address of the first out-of-range access.
- error_is_write  out  1  1 if the first fault was a write.

Behaviour:
- Reset (async assert, sync release):
  - in_ready, out_ready, addr_error, error_is_write = 0; out_data = 0; error_addr = 0.
  - Both FSMs go to IDLE and the read-latency counter clears.
  - RAM contents are not cleared.
  - Reset asserted mid-transaction drops it silently; no ready pulse follows.
- Out-of-range test: in_addr[31:2] >= DEPTH (or out_addr[31:2] >= DEPTH).
- Write FSM (W_IDLE, W_DONE):
  - W_IDLE with in_valid=1: the RAM is written in that cycle, only the bytes with strobe set, and only if in range. Go to W_DONE.
  - W_DONE: in_ready=1 for exactly this cycle, then back to W_IDLE.
  - If in_valid is still high in the cycle after W_DONE, it is a new write.
  - Write latency: in_ready is high exactly 1 cycle after acceptance.
- Read FSM (R_IDLE, R_WAIT, R_READY):
  - R_IDLE with out_valid=1 and in_valid=0: present out_addr to the RAM, load counter = READ_LATENCY, go to R_WAIT.
  - R_WAIT: decrement the counter. When it reaches 1, register the RAM output (0 if out of range) into out_data and go to R_READY.
  - R_READY: out_ready=1 for this cycle only, then back to R_IDLE.
  - Read latency: out_ready is high exactly READ_LATENCY+1 cycles after acceptance.
  - out_valid dropped during R_WAIT: abort to R_IDLE; out_data is unchanged and no pulse is issued.
- Arbitration:
  - in_valid has priority on the RAM port.
  - in_valid=1 while the read FSM is in R_WAIT aborts the read to R_IDLE. The read reissues automatically once in_valid is low, with the latency restarting from that point.
  - A read already in R_READY completes normally.
  - Simultaneous in_valid and out_valid: the write goes first.
- Error record:
  - On the first out-of-range access while addr_error=0: set addr_error, capture error_addr, set error_is_write accordingly.
  - Later faults do not overwrite the record.
  - error_clear=1 clears all three error outputs on the next edge.
  - A fault in the same cycle as error_clear: the fault wins and a new record is captured.
  - A fault is detected in the acceptance cycle only, once per transaction.
- RAM: single port, read-first on the shared port; output is pipelined READ_LATENCY stages.

Decomposition:
- Shared package mem_pkg:
  - w_state_t and r_state_t enums.
  - localparam STRB_WIDTH = DATA_WIDTH/8.
  - Function in_range(addr, depth).
- One sub-module, bram_sp_pipe: inferred single-port RAM with byte-write enables and a READ_LATENCY-stage output pipeline. Parameters: DATA_WIDTH, INDEX_WIDTH, DEPTH, READ_LATENCY.
- Top level holds the FSMs, arbitration and error record.

Test Plan:
- Write 0xDEADBEEF to 0x100 with strb 0xF, then read 0x100 with READ_LATENCY=1 -> in_ready at T+1; out_ready at T+2 after read acceptance; out_data=0xDEADBEEF.
- Write 0x11223344 to 0x200, then write 0xAABBCCDD with strb 0x5, then read 0x200 -> out_data=0x11BB33DD.
- READ_LATENCY=3: read 0x100 with no contention -> out_ready exactly 4 cycles after acceptance. Assert in_valid on cycle 2 of the wait -> read aborts, write completes, read reissues, out_ready 4 cycles after the reissue.
- Write to 0x00280000 (index 655360) -> RAM unchanged, in_ready still pulses, addr_error=1, error_addr=0x00280000, error_is_write=1. A later faulting read at 0x00300000 leaves the record unchanged and returns out_data=0.
- Pulse error_clear in the same cycle as a faulting read at 0x00300000 -> addr_error stays 1, error_addr=0x00300000, error_is_write=0.
- Assert reset_n=0 mid-R_WAIT -> out_ready, addr_error and out_data are 0 immediately. After release, a read of 0x100 returns the previously written value.
